mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Request/response bus types shared by the memory arbiter and its requesters.
package mem_arbiter_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction and data requesters; request at N -> memory valid at N+1.
// One transaction in flight; a losing or blocked request waits in a one-entry pending buffer per port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit arb_mode = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  iarb_in,
    output mem_out_type iarb_out,
    input  mem_in_type  darb_in,
    output mem_out_type darb_out,
    input  mem_out_type imem_out,
    output mem_in_type  imem_in
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t     state;
    mem_in_type pend_i;
    mem_in_type pend_d;
    logic       last_d;

    logic       done;
    logic       can_launch;
    logic       cand_i;
    logic       cand_d;
    logic       grant_i;
    logic       grant_d;
    logic       cap_i;
    logic       cap_d;
    mem_in_type req_sel;

    assign done       = (state != IDLE) && imem_out.mem_ready;
    assign can_launch = (state == IDLE) || done;

    // The owner of the transaction in flight never competes, even in its ready cycle.
    assign cand_i = can_launch && (state != BUSY_I) && (pend_i.mem_valid || iarb_in.mem_valid);
    assign cand_d = can_launch && (state != BUSY_D) && (pend_d.mem_valid || darb_in.mem_valid);

    assign grant_d = cand_d && (!cand_i || arb_mode || !last_d);
    assign grant_i = cand_i && !grant_d;

    // A live pulse is dropped when its pending slot is already occupied.
    assign cap_i = iarb_in.mem_valid && !pend_i.mem_valid && (state != BUSY_I) && !grant_i;
    assign cap_d = darb_in.mem_valid && !pend_d.mem_valid && (state != BUSY_D) && !grant_d;

    always_comb begin
        if (grant_d) begin
            req_sel = pend_d.mem_valid ? pend_d : darb_in;
        end else begin
            req_sel = pend_i.mem_valid ? pend_i : iarb_in;
        end
        req_sel.mem_valid = 1'b1;
    end

    always_comb begin
        iarb_out = '0;
        darb_out = '0;
        if (done && (state == BUSY_I)) begin
            iarb_out = imem_out;
        end
        if (done && (state == BUSY_D)) begin
            darb_out = imem_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pend_i  <= '0;
            pend_d  <= '0;
            last_d  <= 1'b0;
            imem_in <= '0;
        end else begin
            imem_in.mem_valid <= 1'b0;
            if (grant_i || grant_d) begin
                imem_in <= req_sel;
                state   <= grant_d ? BUSY_D : BUSY_I;
                last_d  <= grant_d;
            end else if (done) begin
                state <= IDLE;
            end

            if (grant_i) begin
                pend_i <= '0;
            end else if (cap_i) begin
                pend_i <= iarb_in;
            end

            if (grant_d) begin
                pend_d <= '0;
            end else if (cap_d) begin
                pend_d <= darb_in;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (round-robin, fixed data priority) driven by directed and random requesters.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rstl [2];
    mem_in_type  i_in [2];
    mem_in_type  d_in [2];
    mem_in_type  m_req [2];
    mem_out_type i_out [2];
    mem_out_type d_out [2];
    mem_out_type m_rsp [2];

    always #5 clk = ~clk;

    mem_arbiter #(.arb_mode(1'b0)) u_rr (
        .clk(clk), .rst(rstl[0]),
        .iarb_in(i_in[0]), .iarb_out(i_out[0]),
        .darb_in(d_in[0]), .darb_out(d_out[0]),
        .imem_out(m_rsp[0]), .imem_in(m_req[0])
    );

    mem_arbiter #(.arb_mode(1'b1)) u_fp (
        .clk(clk), .rst(rstl[1]),
        .iarb_in(i_in[1]), .iarb_out(i_out[1]),
        .darb_in(d_in[1]), .darb_out(d_out[1]),
        .imem_out(m_rsp[1]), .imem_in(m_req[1])
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference state, index k = 2*lane + port (port 0 = instruction, 1 = data).
    bit          w_vld  [4];
    int          w_tag  [4];
    mem_in_type  w_req  [4];
    bit          outst  [4];
    logic [31:0] exp_q  [4][$];
    bit          busy   [2];
    int          owner  [2];
    mem_in_type  cur    [2];
    int          last_p [2];
    int          grants [2];
    int          mem_cnt[2];
    bit          stray  [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input mem_in_type r);
        return {r.mem_addr[15:0], r.mem_addr[31:16]} ^ r.mem_wdata ^ {28'h0, r.mem_wstrb} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int ln);
        @(posedge clk);
        #1;
        i_in[ln].mem_valid = 1'b0;
        d_in[ln].mem_valid = 1'b0;
    endtask

    task automatic issue(input int ln, input int p, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
        mem_in_type r;
        int k = 2 * ln + p;
        r.mem_valid = 1'b1;
        r.mem_instr = (p == 0);
        r.mem_addr  = addr;
        r.mem_wdata = wd;
        r.mem_wstrb = ws;
        if (p == 0) i_in[ln] = r;
        else        d_in[ln] = r;
        w_vld[k] = 1'b1;
        w_tag[k] = cyc + 1;
        w_req[k] = r;
        outst[k] = 1'b1;
        exp_q[k].push_back(mem_fn(r));
    endtask

    task automatic do_reset(input int ln);
        rstl[ln]    = 1'b0;
        i_in[ln]    = '0;
        d_in[ln]    = '0;
        m_rsp[ln]   = '0;
        mem_cnt[ln] = 0;
        stray[ln]   = 1'b0;
        busy[ln]    = 1'b0;
        last_p[ln]  = 0;
        for (int p = 0; p < 2; p++) begin
            w_vld[2*ln+p] = 1'b0;
            outst[2*ln+p] = 1'b0;
            exp_q[2*ln+p].delete();
        end
        #1;
        check("reset_mem_req", 128'(m_req[ln]), '0);
        check("reset_outputs", 128'({i_out[ln], d_out[ln]}), '0);
        tick(ln);
        tick(ln);
        rstl[ln] = 1'b1;
    endtask

    task automatic wait_idle(input int ln);
        int n = 0;
        while ((outst[2*ln] || outst[2*ln+1]) && n < 100) begin
            tick(ln);
            n++;
        end
        check("drain_timeout", 128'({outst[2*ln], outst[2*ln+1]}), '0);
    endtask

    // Scoreboard/monitor: completions, launches, held fields and launch promptness.
    task automatic mon(input int ln);
        int ki = 2 * ln;
        int kd = 2 * ln + 1;
        int k;
        int p;
        bit ei;
        bit ed;
        bit done_now = 1'b0;
        logic [31:0] rd;
        mem_in_type exp_req;

        if (m_rsp[ln].mem_ready && busy[ln]) begin
            k = 2 * ln + owner[ln];
            check("rsp_expected", 128'(exp_q[k].size() != 0), 128'(1));
            rd = (exp_q[k].size() != 0) ? exp_q[k].pop_front() : 32'h0;
            if (owner[ln] == 0) begin
                check("i_response", 128'(i_out[ln]), 128'({1'b1, rd}));
                check("d_quiet", 128'(d_out[ln]), '0);
            end else begin
                check("d_response", 128'(d_out[ln]), 128'({1'b1, rd}));
                check("i_quiet", 128'(i_out[ln]), '0);
            end
            outst[k]  = 1'b0;
            busy[ln]  = 1'b0;
            done_now  = 1'b1;
        end else begin
            check("outputs_zero", 128'({i_out[ln], d_out[ln]}), '0);
        end

        ei = w_vld[ki] && (w_tag[ki] <= cyc);
        ed = w_vld[kd] && (w_tag[kd] <= cyc);
        if (m_req[ln].mem_valid) begin
            check("launch_while_busy", 128'(busy[ln]), '0);
            check("launch_has_request", 128'(ei || ed), 128'(1));
            if (ei || ed) begin
                if (ei && ed) p = (ln == 1 || last_p[ln] == 0) ? 1 : 0;
                else          p = ed ? 1 : 0;
                k = 2 * ln + p;
                check("launch_request", 128'(m_req[ln]), 128'(w_req[k]));
                w_vld[k]    = 1'b0;
                last_p[ln]  = p;
                owner[ln]   = p;
                cur[ln]     = w_req[k];
                busy[ln]    = 1'b1;
                grants[ln]++;
                mem_cnt[ln] = $urandom_range(1, 3);
            end
        end else if (busy[ln]) begin
            exp_req = cur[ln];
            exp_req.mem_valid = 1'b0;
            check("request_held", 128'(m_req[ln]), 128'(exp_req));
        end else if (!done_now) begin
            check("waiting_not_launched", 128'(ei || ed), '0);
        end
    endtask

    always @(negedge clk) begin
        for (int ln = 0; ln < 2; ln++) begin
            if (rstl[ln] === 1'b1) mon(ln);
        end
    end

    // Memory model: variable latency, rdata derived from the request it sees.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int ln = 0; ln < 2; ln++) begin
                m_rsp[ln] = '0;
                if (stray[ln]) begin
                    m_rsp[ln].mem_ready = 1'b1;
                    m_rsp[ln].mem_rdata = 32'hBAD0_0BAD;
                    stray[ln] = 1'b0;
                end else if (mem_cnt[ln] > 0) begin
                    mem_cnt[ln]--;
                    if (mem_cnt[ln] == 0) begin
                        m_rsp[ln].mem_ready = 1'b1;
                        m_rsp[ln].mem_rdata = mem_fn(m_req[ln]);
                    end
                end
            end
        end
    end

    task automatic run_lane(input int ln);
        int g0;
        do_reset(ln);

        issue(ln, 0, 32'h0000_0100, 32'h0, 4'h0);
        tick(ln);
        wait_idle(ln);

        issue(ln, 0, 32'h0000_0010, 32'h0, 4'h0);
        issue(ln, 1, 32'h0000_0020, 32'h0, 4'h0);
        tick(ln);
        wait_idle(ln);

        issue(ln, 1, 32'h0000_0024, 32'h0, 4'h0);
        tick(ln);
        wait_idle(ln);
        issue(ln, 0, 32'h0000_0014, 32'h0, 4'h0);
        issue(ln, 1, 32'h0000_0028, 32'h0, 4'h0);
        tick(ln);
        wait_idle(ln);

        g0 = grants[ln];
        for (int n = 0; n < 200 && grants[ln] < g0 + 6; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!outst[2*ln+p]) issue(ln, p, 32'h1000 + 32'(grants[ln] * 16 + p * 8), $urandom, 4'h0);
            end
            tick(ln);
        end
        check("six_grants_served", 128'(grants[ln] >= g0 + 6), 128'(1));
        wait_idle(ln);

        issue(ln, 0, 32'h0000_0200, 32'h0, 4'h0);
        tick(ln);
        issue(ln, 1, 32'h0000_0040, 32'h1234_5678, 4'hF);
        tick(ln);
        wait_idle(ln);

        issue(ln, 1, 32'h0000_0300, 32'h0, 4'h0);
        tick(ln);
        issue(ln, 0, 32'h0000_0A00, 32'h0, 4'h0);
        tick(ln);
        i_in[ln].mem_valid = 1'b1;
        i_in[ln].mem_addr  = 32'h0000_0B00;
        tick(ln);
        wait_idle(ln);

        stray[ln] = 1'b1;
        tick(ln);
        tick(ln);
        tick(ln);

        issue(ln, 1, 32'h0000_0500, 32'h0, 4'h0);
        tick(ln);
        issue(ln, 0, 32'h0000_0600, 32'h0, 4'h0);
        tick(ln);
        do_reset(ln);
        stray[ln] = 1'b1;
        tick(ln);
        tick(ln);
        tick(ln);
        issue(ln, 0, 32'h0000_0700, 32'h0, 4'h0);
        tick(ln);
        wait_idle(ln);

        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!outst[2*ln+p] && $urandom_range(0, 3) == 0)
                    issue(ln, p, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
            end
            tick(ln);
        end
        wait_idle(ln);
    endtask

    initial begin
        fork
            run_lane(0);
            run_lane(1);
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end
endmodule
